// File: rtl/up_down_counter_pkg.sv
// Shared constants for the up/down counter: encoding of the direction select.
package up_down_counter_pkg;

  // Direction select values driven on the mode input
  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage : up_down_counter_pkg

// File: rtl/up_down_counter.sv
// Free-running modulo-2^WIDTH up/down counter.
// mode selects the direction every cycle; tc flags the cycle before a wrap.
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO      = '0;

  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] count_next;

  // Single adder: adding all-ones is a decrement modulo 2^WIDTH, so one adder covers both directions
  always_comb begin
    step       = (mode == MODE_DOWN) ? ALL_ONES : ONE;
    count_next = count + step;
  end

  // Count register: synchronous reset wins over mode, otherwise step every edge
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_COUNT;
    end else begin
      count <= count_next;
    end
  end

  // Terminal count: the value that will wrap on the next edge in the current direction
  always_comb begin
    if (mode == MODE_UP) begin
      tc = (count == ALL_ONES);
    end else begin
      tc = (count == ZERO);
    end
  end

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
// Directed bench for up_down_counter: a WIDTH=3 instance driven from a vector
// table and a WIDTH=4/RESET_VAL=9 instance driven by hand-written sequences.
module tb_up_down_counter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst3, mode3;
  logic rst4, mode4;
  logic [2:0] count3;
  logic [3:0] count4;
  logic tc3, tc4;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst3  = 1'b1;
    mode3 = 1'b0;
    rst4  = 1'b1;
    mode4 = 1'b0;
  end

  up_down_counter #(.WIDTH(3), .RESET_VAL(0)) u_dut3 (
    .clk   (clk),
    .rst   (rst3),
    .mode  (mode3),
    .count (count3),
    .tc    (tc3)
  );

  up_down_counter #(.WIDTH(4), .RESET_VAL(9)) u_dut4 (
    .clk   (clk),
    .rst   (rst4),
    .mode  (mode4),
    .count (count4),
    .tc    (tc4)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q[$];

  task automatic check_val(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       mode;
    logic [2:0] exp_count;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic m, input logic [2:0] c, input logic t);
    vec_t v;
    v.rst       = r;
    v.mode      = m;
    v.exp_count = c;
    v.exp_tc    = t;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after an edge; outputs are sampled at the same point
  task automatic step3(input logic r, input logic m, input logic [2:0] ec, input logic etc, input int idx);
    rst3  = r;
    mode3 = m;
    exp_q.push_back({1'b0, ec});
    @(posedge clk);
    #1;
    check_val($sformatf("vec%0d_count", idx), {1'b0, count3}, exp_q.pop_front());
    check_bit($sformatf("vec%0d_tc", idx), tc3, etc);
  endtask

  task automatic step4(input string name, input logic r, input logic m, input logic [3:0] ec, input logic etc);
    rst4  = r;
    mode4 = m;
    exp_q.push_back(ec);
    @(posedge clk);
    #1;
    check_val({name, "_count"}, count4, exp_q.pop_front());
    check_bit({name, "_tc"}, tc4, etc);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

  // ---------------- main test ----------------
  initial begin
    // reset, held for several edges; mode ignored during reset
    add(1, 0, 3'd0, 0);
    add(1, 0, 3'd0, 0);
    add(1, 1, 3'd0, 1);
    // up count with wrap
    add(0, 0, 3'd1, 0);
    add(0, 0, 3'd2, 0);
    add(0, 0, 3'd3, 0);
    add(0, 0, 3'd4, 0);
    add(0, 0, 3'd5, 0);
    add(0, 0, 3'd6, 0);
    add(0, 0, 3'd7, 1);
    add(0, 0, 3'd0, 0);
    add(0, 0, 3'd1, 0);
    add(0, 0, 3'd2, 0);
    add(0, 0, 3'd3, 0);
    add(0, 0, 3'd4, 0);
    add(0, 0, 3'd5, 0);
    add(0, 0, 3'd6, 0);
    // direction change at 6: next is 5, then down wrap 0 -> 7
    add(0, 1, 3'd5, 0);
    add(0, 1, 3'd4, 0);
    add(0, 1, 3'd3, 0);
    add(0, 1, 3'd2, 0);
    add(0, 1, 3'd1, 0);
    add(0, 1, 3'd0, 1);
    add(0, 1, 3'd7, 0);
    // back to up at 7 wraps to 0, then down again wraps to 7
    add(0, 0, 3'd0, 0);
    add(0, 1, 3'd7, 0);
    add(0, 1, 3'd6, 0);
    add(0, 1, 3'd5, 0);
    add(0, 1, 3'd4, 0);
    // reset mid-count while counting down, then resume downward
    add(1, 1, 3'd0, 1);
    add(0, 1, 3'd7, 0);
    add(0, 0, 3'd0, 0);
    add(0, 0, 3'd1, 0);

    // first edge at t=5 passes with rst already high
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      step3(vecs[i].rst, vecs[i].mode, vecs[i].exp_count, vecs[i].exp_tc, i);
    end

    // tc is combinational in mode: count3 is 1 here, so neither direction flags it
    mode3 = 1'b1;
    #1;
    check_bit("w3_tc_mode_flip_at1", tc3, 1'b0);

    // WIDTH=4, RESET_VAL=9
    step4("w4_reset", 1, 0, 4'd9, 0);
    step4("w4_up10", 0, 0, 4'd10, 0);
    step4("w4_up11", 0, 0, 4'd11, 0);
    step4("w4_up12", 0, 0, 4'd12, 0);
    step4("w4_up13", 0, 0, 4'd13, 0);
    step4("w4_up14", 0, 0, 4'd14, 0);
    step4("w4_up15", 0, 0, 4'd15, 1);
    // tc drops combinationally when the direction flips at 15
    mode4 = 1'b1;
    #1;
    check_bit("w4_tc_down_at15", tc4, 1'b0);
    mode4 = 1'b0;
    #1;
    check_bit("w4_tc_up_at15", tc4, 1'b1);
    step4("w4_upwrap", 0, 0, 4'd0, 0);
    // at 0, switching to down raises tc before the edge
    mode4 = 1'b1;
    #1;
    check_bit("w4_tc_down_at0", tc4, 1'b1);
    step4("w4_downwrap", 0, 1, 4'd15, 0);
    step4("w4_down14", 0, 1, 4'd14, 0);
    step4("w4_reset_mid", 1, 1, 4'd9, 0);
    step4("w4_down8", 0, 1, 4'd8, 0);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL exp_q_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_up_down_counter
